// File: rtl/pb_hub_pkg.sv
// pb_hub_pkg: shared constants for the pb_mailbox_hub input-port hub.
//   SEL_*  : port_id[7:6] function select codes
//   ST_*   : bit positions inside the status byte {occ[4:0], udf, full, empty}
//   OCC_SAT: occupancy value reported when a channel holds more entries
package pb_hub_pkg;

  localparam logic [1:0] SEL_DATA  = 2'b00;
  localparam logic [1:0] SEL_STAT  = 2'b01;
  localparam logic [1:0] SEL_FLUSH = 2'b10;
  localparam logic [1:0] SEL_XOR   = 2'b11;

  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_UDF     = 2;
  localparam int unsigned ST_OCC_LSB = 3;

  localparam int unsigned OCC_SAT = 31;

endpackage

// File: rtl/pb_hub_fifo.sv
// pb_hub_fifo: one mailbox channel, synchronous FIFO of DEPTH bytes.
// Ports:
//   clk, reset : clock, synchronous active-high reset (pointers only)
//   push       : write request; ignored while full
//   pop        : advance head; caller guarantees the FIFO is non-empty
//   flush      : empty the FIFO; overrides push and pop in the same cycle
//   din        : byte to push
//   head       : current head byte (valid when !empty)
//   occ        : number of stored entries, 0..DEPTH
//   full/empty : registered-state status
module pb_hub_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [7:0]                 din,
  output logic [7:0]                 head,
  output logic [$clog2(DEPTH):0]     occ,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        push_ok;

  // Extra MSB on each pointer distinguishes full from empty when the
  // index bits match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign occ     = wptr - rptr;
  assign head    = mem[rptr[AW-1:0]];
  assign push_ok = push && !full;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
    end
  end

  // Storage is not reset; a write during flush is harmless since wptr is cleared.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pb_mailbox_hub.sv
// pb_mailbox_hub: N_CH buffered mailbox channels presented to a KCPSM3
// master through its port_id / read_strobe / write_strobe bus.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   port_id      : [7:6] select (data/status/flush/xor), low bits channel
//   read_strobe  : master INPUT strobe, pops the addressed data channel
//   write_strobe : master OUTPUT strobe, used for flush
//   out_port     : flush command, bit0 also clears the sticky underflow flag
//   in_port      : registered read data (1-cycle latency from port_id)
//   wr_valid/wr_data/wr_ready : per-channel producer push interface
//   irq          : registered, any channel non-empty
// Build option: define PB_HUB_XOR_EN to make SEL=11 the vernam port
// (head[CH] ^ head[CH^1], popping both channels).
module pb_mailbox_hub
  import pb_hub_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           port_id,
  input  logic                 read_strobe,
  input  logic                 write_strobe,
  input  logic [7:0]           out_port,
  output logic [7:0]           in_port,
  input  logic [N_CH-1:0]      wr_valid,
  input  logic [8*N_CH-1:0]    wr_data,
  output logic [N_CH-1:0]      wr_ready,
  output logic                 irq
);

  localparam int unsigned CH_W  = (N_CH > 2) ? $clog2(N_CH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic [7:0]       head  [N_CH];
  logic [OCC_W-1:0] occ   [N_CH];
  logic [N_CH-1:0]  full;
  logic [N_CH-1:0]  empty;
  logic [N_CH-1:0]  pop_v;
  logic [N_CH-1:0]  flush_v;
  logic [N_CH-1:0]  udf;
  logic [N_CH-1:0]  udf_set;
  logic [N_CH-1:0]  udf_clr;
  logic [N_CH-1:0]  ch_hit;

  logic [1:0]       sel;
  logic [CH_W-1:0]  ch;
  logic             mapped;
  logic [7:0]       sel_head;
  logic [OCC_W-1:0] sel_occ;
  logic             sel_full;
  logic             sel_empty;
  logic             sel_udf;
  logic [4:0]       occ_sat;
  logic [7:0]       status;
  logic [7:0]       rd_next;
  logic             rd_data;

  // Bits of port_id above the channel field and out_port[7:1] carry no meaning.
  logic             unused_bits;
  assign unused_bits = ^{port_id, out_port[7:1]};

  assign sel      = port_id[7:6];
  assign ch       = port_id[CH_W-1:0];
  assign wr_ready = ~full;
  assign rd_data  = read_strobe && (sel == SEL_DATA);

  generate
    for (genvar c = 0; c < N_CH; c++) begin : gen_ch
      pb_hub_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_valid[c]),
        .pop   (pop_v[c]),
        .flush (flush_v[c]),
        .din   (wr_data[8*c +: 8]),
        .head  (head[c]),
        .occ   (occ[c]),
        .full  (full[c]),
        .empty (empty[c])
      );
    end
  endgenerate

  // One-hot channel decode; an unmapped CH leaves ch_hit all-zero, which
  // naturally suppresses pops, flushes and read data.
  always_comb begin
    ch_hit    = '0;
    sel_head  = '0;
    sel_occ   = '0;
    sel_full  = 1'b0;
    sel_empty = 1'b1;
    sel_udf   = 1'b0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      ch_hit[c] = (ch == CH_W'(c));
      if (ch_hit[c]) begin
        sel_head  = head[c];
        sel_occ   = occ[c];
        sel_full  = full[c];
        sel_empty = empty[c];
        sel_udf   = udf[c];
      end
    end
  end

  assign mapped = |ch_hit;

  always_comb begin
    occ_sat = (32'(sel_occ) > OCC_SAT) ? 5'(OCC_SAT) : 5'(sel_occ);
    status  = '0;
    status[ST_EMPTY] = sel_empty;
    status[ST_FULL]  = sel_full;
    status[ST_UDF]   = sel_udf;
    status[7:ST_OCC_LSB] = occ_sat;
  end

`ifdef PB_HUB_XOR_EN
  logic [CH_W-1:0] partner;
  logic [N_CH-1:0] p_hit;
  logic [7:0]      p_head;
  logic            p_empty;
  logic            p_mapped;
  logic            xor_rd;
  logic            xor_ok;

  assign partner = ch ^ CH_W'(1);
  assign xor_rd  = read_strobe && (sel == SEL_XOR);

  always_comb begin
    p_hit   = '0;
    p_head  = '0;
    p_empty = 1'b1;
    for (int unsigned c = 0; c < N_CH; c++) begin
      p_hit[c] = (partner == CH_W'(c));
      if (p_hit[c]) begin
        p_head  = head[c];
        p_empty = empty[c];
      end
    end
  end

  assign p_mapped = |p_hit;
  assign xor_ok   = mapped && p_mapped && !sel_empty && !p_empty;
`endif

  always_comb begin
    pop_v   = '0;
    udf_set = '0;
    flush_v = '0;
    udf_clr = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      pop_v[c]   = rd_data && ch_hit[c] && !empty[c];
      udf_set[c] = rd_data && ch_hit[c] && empty[c];
      flush_v[c] = write_strobe && (sel == SEL_FLUSH) && ch_hit[c];
      udf_clr[c] = flush_v[c] && out_port[0];
`ifdef PB_HUB_XOR_EN
      // The vernam read is all-or-nothing: both heads pop, or neither does
      // and every empty participant records an underflow.
      if (xor_rd && (ch_hit[c] || p_hit[c])) begin
        pop_v[c]   = xor_ok;
        udf_set[c] = !xor_ok && empty[c];
      end
`endif
    end
  end

  always_comb begin
    rd_next = '0;
    case (sel)
      SEL_DATA: rd_next = (mapped && !sel_empty) ? sel_head : '0;
      SEL_STAT: rd_next = mapped ? status : '0;
`ifdef PB_HUB_XOR_EN
      SEL_XOR:  rd_next = xor_ok ? (sel_head ^ p_head) : '0;
`endif
      default:  rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_port <= '0;
      irq     <= 1'b0;
      udf     <= '0;
    end else begin
      in_port <= rd_next;
      irq     <= |(~empty);
      udf     <= (udf & ~udf_clr) | udf_set;
    end
  end

endmodule

// File: tb/tb_pb_mailbox_hub.sv
module tb_pb_mailbox_hub;
  import pb_hub_pkg::*;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CH_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        port_id;
  logic              read_strobe;
  logic              write_strobe;
  logic [7:0]        out_port;
  logic [7:0]        in_port;
  logic [N_CH-1:0]   wr_valid;
  logic [8*N_CH-1:0] wr_data;
  logic [N_CH-1:0]   wr_ready;
  logic              irq;

  int checks = 0;
  int errors = 0;

  // Reference model: one byte queue and one sticky flag per channel.
  logic [7:0] q [N_CH][$];
  logic       udf_m [N_CH];

  pb_mailbox_hub #(.N_CH(N_CH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .read_strobe  (read_strobe),
    .write_strobe (write_strobe),
    .out_port     (out_port),
    .in_port      (in_port),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    read_strobe  = 1'b0;
    write_strobe = 1'b0;
    out_port     = '0;
    wr_valid     = '0;
    wr_data      = '0;
  endtask

  function automatic logic [7:0] model_status(input int unsigned c);
    int unsigned n;
    logic [4:0]  o;
    n = q[c].size();
    o = (n > 31) ? 5'd31 : 5'(n);
    return {o, udf_m[c], (n == DEPTH), (n == 0)};
  endfunction

  // Predict the effect of the current inputs at the next edge, advance
  // one clock and compare the registered outputs.
  task automatic step();
    logic [7:0]      exp_in;
    logic            exp_irq;
    logic [N_CH-1:0] exp_rdy;
    logic [1:0]      sel;
    int unsigned     ch;
    int unsigned     p;
    logic            pop   [N_CH];
    logic            fl    [N_CH];
    logic            acc   [N_CH];
    sel     = port_id[7:6];
    ch      = port_id[CH_W-1:0];
    p       = ch ^ 1;
    exp_in  = '0;
    exp_irq = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (q[c].size() != 0) exp_irq = 1'b1;
      pop[c] = 1'b0;
      fl[c]  = 1'b0;
      acc[c] = wr_valid[c] && (q[c].size() < DEPTH);
    end
    if (reset) begin
      exp_irq = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        q[c].delete();
        udf_m[c] = 1'b0;
      end
    end else begin
      if (ch < N_CH) begin
        if (sel == SEL_DATA && q[ch].size() != 0) exp_in = q[ch][0];
        if (sel == SEL_STAT) exp_in = model_status(ch);
        if (read_strobe && sel == SEL_DATA) begin
          if (q[ch].size() != 0) pop[ch] = 1'b1;
          else udf_m[ch] = 1'b1;
        end
`ifdef PB_HUB_XOR_EN
        if (sel == SEL_XOR && p < N_CH && q[ch].size() != 0 && q[p].size() != 0) begin
          exp_in = q[ch][0] ^ q[p][0];
          if (read_strobe) begin
            pop[ch] = 1'b1;
            pop[p]  = 1'b1;
          end
        end else if (sel == SEL_XOR && read_strobe) begin
          if (q[ch].size() == 0) udf_m[ch] = 1'b1;
          if (p < N_CH && q[p].size() == 0) udf_m[p] = 1'b1;
        end
`endif
        if (write_strobe && sel == SEL_FLUSH) begin
          fl[ch] = 1'b1;
          if (out_port[0]) udf_m[ch] = 1'b0;
        end
      end
      for (int c = 0; c < N_CH; c++) begin
        if (fl[c]) q[c].delete();
        else begin
          if (pop[c]) void'(q[c].pop_front());
          if (acc[c]) q[c].push_back(wr_data[8*c +: 8]);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < N_CH; c++) exp_rdy[c] = (q[c].size() < DEPTH);
    chk("in_port", in_port, exp_in);
    chk("irq", irq, exp_irq);
    chk("wr_ready", wr_ready, exp_rdy);
  endtask

  task automatic do_push(input int c, input logic [7:0] d);
    idle();
    wr_valid[c]       = 1'b1;
    wr_data[8*c +: 8] = d;
    step();
    idle();
  endtask

  task automatic do_read(input logic [7:0] pid);
    idle();
    port_id     = pid;
    read_strobe = 1'b1;
    step();
    idle();
  endtask

  task automatic do_peek(input logic [7:0] pid);
    idle();
    port_id = pid;
    step();
  endtask

  task automatic do_flush(input int c, input logic [7:0] op);
    idle();
    port_id      = 8'h80 | 8'(c);
    write_strobe = 1'b1;
    out_port     = op;
    step();
    idle();
  endtask

  initial begin
    logic [7:0] b;
    idle();
    port_id = '0;
    for (int c = 0; c < N_CH; c++) udf_m[c] = 1'b0;

    // Reset with a pending read strobe; reset must win.
    reset       = 1'b1;
    read_strobe = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("reset_in_port", in_port, 8'h00);
    chk("reset_wr_ready", wr_ready, 4'hF);
    chk("reset_irq", irq, 1'b0);
    reset = 1'b0;
    idle();
    for (int c = 0; c < N_CH; c++) begin
      do_peek(8'h40 | 8'(c));
      chk("reset_status", in_port, 8'h01);
    end

    // Fill and drain ch2.
    for (int i = 0; i < 8; i++) do_push(2, 8'h10 + 8'(i));
    chk("ch2_full_ready", wr_ready[2], 1'b0);
    do_peek(8'h42);
    chk("ch2_full_status", in_port, 8'h42);
    for (int i = 0; i < 8; i++) begin
      do_read(8'h02);
      chk("ch2_drain", in_port, 8'h10 + 8'(i));
    end
    do_peek(8'h42);
    chk("ch2_empty_status", in_port, 8'h01);
    chk("ch2_irq_clear", irq, 1'b0);

    // Underflow on ch1, then flush with udf clear.
    do_read(8'h01);
    chk("udf_read", in_port, 8'h00);
    do_peek(8'h41);
    chk("udf_status", in_port, 8'h05);
    do_flush(1, 8'h01);
    do_peek(8'h41);
    chk("udf_cleared", in_port, 8'h01);

    // Ch0 full: simultaneous push rejected, pop proceeds.
    for (int i = 0; i < 8; i++) do_push(0, 8'h20 + 8'(i));
    idle();
    port_id     = 8'h00;
    read_strobe = 1'b1;
    wr_valid[0] = 1'b1;
    wr_data[7:0] = 8'hEE;
    step();
    idle();
    chk("full_pushpop_data", in_port, 8'h20);
    do_peek(8'h40);
    chk("full_pushpop_occ", in_port, 8'h38);

    // Ch0 at occupancy 3: push+pop keeps occupancy.
    do_flush(0, 8'h00);
    for (int i = 0; i < 3; i++) do_push(0, 8'h30 + 8'(i));
    idle();
    port_id      = 8'h00;
    read_strobe  = 1'b1;
    wr_valid[0]  = 1'b1;
    wr_data[7:0] = 8'h33;
    step();
    idle();
    chk("mid_pushpop_data", in_port, 8'h30);
    do_peek(8'h40);
    chk("mid_pushpop_occ", in_port, 8'h18);

    // Flush and push together: flush wins.
    idle();
    port_id      = 8'h80;
    write_strobe = 1'b1;
    wr_valid[0]  = 1'b1;
    wr_data[7:0] = 8'h44;
    step();
    idle();
    do_peek(8'h40);
    chk("flush_push_status", in_port, 8'h01);

    // Pop of an empty channel while a push lands: underflow plus accepted push.
    idle();
    port_id      = 8'h00;
    read_strobe  = 1'b1;
    wr_valid[0]  = 1'b1;
    wr_data[7:0] = 8'h5A;
    step();
    idle();
    do_peek(8'h00);
    chk("empty_pushpop_head", in_port, 8'h5A);
    do_flush(0, 8'h01);

    // Wrap-around through ch3 with low occupancy.
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      do_push(3, b);
      do_read(8'h03);
      chk("wrap_data", in_port, b);
      do_peek(8'h43);
      chk("wrap_not_full", in_port[ST_FULL], 1'b0);
    end

`ifdef PB_HUB_XOR_EN
    idle();
    wr_valid     = 4'b0011;
    wr_data[7:0] = 8'hA5;
    wr_data[15:8] = 8'h3C;
    step();
    idle();
    do_read(8'hC0);
    chk("xor_data", in_port, 8'h99);
    do_peek(8'h40);
    chk("xor_ch0_empty", in_port, 8'h01);
    do_peek(8'h41);
    chk("xor_ch1_empty", in_port, 8'h01);
    do_push(0, 8'hA5);
    do_read(8'hC0);
    chk("xor_partial", in_port, 8'h00);
    do_peek(8'h40);
    chk("xor_ch0_kept", in_port, 8'h08);
    do_peek(8'h41);
    chk("xor_ch1_udf", in_port, 8'h05);
    do_flush(0, 8'h01);
    do_flush(1, 8'h01);
`endif

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      idle();
      port_id      = 8'($urandom);
      read_strobe  = ($urandom_range(0, 1) == 1);
      write_strobe = ($urandom_range(0, 7) == 0);
      out_port     = 8'($urandom);
      wr_valid     = 4'($urandom);
      wr_data      = $urandom;
      reset        = ($urandom_range(0, 199) == 0);
      step();
      reset = 1'b0;
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
